// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous-read sprite ROM port among NUM_REQ draw engines.
// Returns each pixel tagged with requester id; out-of-range addresses come back flagged with zero data.
module sprite_rom_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 2,
  parameter int ROM_DEPTH = 6240,
  parameter int ROM_LAT   = 1,
  localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       arb_en_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic [ADDR_W-1:0]          rom_addr_o,
  input  logic [DATA_W-1:0]          rom_data_i,
  output logic                       rsp_valid_o,
  output logic [ID_W-1:0]            rsp_id_o,
  output logic [DATA_W-1:0]          rsp_data_o,
  output logic                       rsp_err_o
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(ROM_DEPTH);

  logic [ADDR_W-1:0] addr_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi] = req_addr_i[gi*ADDR_W +: ADDR_W];
    end
  endgenerate

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic               grant_any;
  logic [ID_W-1:0]    grant_id;
  logic [ID_W-1:0]    idx;
  logic [NUM_REQ-1:0] grant_oh;
  logic [ADDR_W-1:0]  sel_addr;
  logic               in_range;

  // Search starts at the pointer and wraps; the first valid requester wins.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    grant_oh  = '0;
    idx       = '0;
    if (arb_en_i && rst_ni) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = ID_W'((32'(ptr_q) + k) % NUM_REQ);
        if (!grant_any && req_valid_i[idx]) begin
          grant_any = 1'b1;
          grant_id  = idx;
        end
      end
    end
    grant_oh[grant_id] = grant_any;
  end

  assign sel_addr    = addr_arr[grant_id];
  assign in_range    = ({1'b0, sel_addr} < DEPTH_C);
  assign req_ready_o = grant_oh;
  assign rom_addr_o  = (grant_any && in_range) ? sel_addr : '0;

  assign ptr_d = !grant_any ? ptr_q :
                 (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

  // Tag pipeline matches the ROM read latency; id/err are cleared on bubbles.
  logic            vld_q [ROM_LAT];
  logic [ID_W-1:0] id_q  [ROM_LAT];
  logic            err_q [ROM_LAT];

  generate
    for (genvar gi = 0; gi < ROM_LAT; gi++) begin : g_pipe
      logic            vld_d;
      logic [ID_W-1:0] id_d;
      logic            err_d;
      if (gi == 0) begin : g_head
        assign vld_d = grant_any;
        assign id_d  = grant_any ? grant_id : '0;
        assign err_d = grant_any && !in_range;
      end else begin : g_tail
        assign vld_d = vld_q[gi-1];
        assign id_d  = id_q[gi-1];
        assign err_d = err_q[gi-1];
      end
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          vld_q[gi] <= 1'b0;
          id_q[gi]  <= '0;
          err_q[gi] <= 1'b0;
        end else begin
          vld_q[gi] <= vld_d;
          id_q[gi]  <= id_d;
          err_q[gi] <= err_d;
        end
      end
    end
  endgenerate

  assign rsp_valid_o = vld_q[ROM_LAT-1];
  assign rsp_id_o    = id_q[ROM_LAT-1];
  assign rsp_err_o   = err_q[ROM_LAT-1];
  assign rsp_data_o  = (vld_q[ROM_LAT-1] && !err_q[ROM_LAT-1]) ? rom_data_i : '0;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter: stimulus pushes hand-computed responses,
// a negedge monitor pops and compares every response the DUT presents.
module tb_sprite_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arb_en;
  logic [3:0]  req_valid;
  logic [51:0] req_addr;
  logic [3:0]  req_ready;
  logic [12:0] rom_addr;
  logic [1:0]  rom_data = 2'd0;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [1:0]  rsp_data;
  logic        rsp_err;

  int errors = 0;
  int checks = 0;
  logic [4:0] sb_q [$];
  logic [4:0] mon_e;

  always #5 clk = ~clk;

  // Behavioural synchronous ROM: data = addr[1:0]
  always @(posedge clk) rom_data <= rom_addr[1:0];

  sprite_rom_arbiter #(
    .NUM_REQ(4), .ADDR_W(13), .DATA_W(2), .ROM_DEPTH(6240), .ROM_LAT(1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .arb_en_i(arb_en),
    .req_valid_i(req_valid), .req_addr_i(req_addr), .req_ready_o(req_ready),
    .rom_addr_o(rom_addr), .rom_data_i(rom_data),
    .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rsp_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got id=%0d err=%0d data=%0d, required none (t=%0t)",
                 rsp_id, rsp_err, rsp_data, $time);
      end else begin
        mon_e = sb_q.pop_front();
        $display("rsp id=%0d err=%0d data=%0d (exp id=%0d err=%0d data=%0d)",
                 rsp_id, rsp_err, rsp_data, mon_e[4:3], mon_e[2], mon_e[1:0]);
        chk("rsp_id", int'(rsp_id), int'(mon_e[4:3]));
        chk("rsp_err", int'(rsp_err), int'(mon_e[2]));
        chk("rsp_data", int'(rsp_data), int'(mon_e[1:0]));
      end
    end else begin
      chk("idle_rsp_fields", int'({rsp_id, rsp_err, rsp_data}), 0);
    end
  end

  // One request cycle: drive, check the grant, push the expected response if a grant is expected.
  task automatic drive(input logic en, input logic [3:0] v, input logic [51:0] a,
                       input logic [3:0] exp_rdy, input logic [1:0] exp_id,
                       input logic exp_err, input logic [1:0] exp_data);
    @(posedge clk);
    #2;
    arb_en    = en;
    req_valid = v;
    req_addr  = a;
    #1;
    $display("req en=%0b valid=%b ready=%b (exp %b) rom_addr=%0d", en, v, req_ready, exp_rdy, rom_addr);
    chk("req_ready", int'(req_ready), int'(exp_rdy));
    if (exp_rdy != 4'b0000) sb_q.push_back({exp_id, exp_err, exp_data});
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  localparam logic [51:0] ADDR_0123 = {13'd3, 13'd2, 13'd1, 13'd0};

  initial begin
    rst_n     = 1'b0;
    arb_en    = 1'b1;
    req_valid = 4'b1111;
    req_addr  = ADDR_0123;
    #3;
    chk("reset_req_ready", int'(req_ready), 0);
    chk("reset_rom_addr", int'(rom_addr), 0);
    chk("reset_rsp", int'({rsp_valid, rsp_id, rsp_err, rsp_data}), 0);
    req_valid = 4'b0000;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: only req 2, addr 5
    drive(1'b1, 4'b0100, {13'd0, 13'd5, 13'd0, 13'd0}, 4'b0100, 2'd2, 1'b0, 2'd1);
    chk("t1_rom_addr", int'(rom_addr), 5);
    drive(1'b1, 4'b0000, '0, 4'b0000, 2'd0, 1'b0, 2'd0);

    // 2: all valid after reset, accept order 0,1,2,3,0,1,2,3
    do_reset();
    for (int k = 0; k < 8; k++)
      drive(1'b1, 4'b1111, ADDR_0123, 4'b0001 << (k % 4), 2'(k % 4), 1'b0, 2'(k % 4));

    // 3: move p to 1, then req1 out of range and req3 at the last legal address
    drive(1'b1, 4'b0001, '0, 4'b0001, 2'd0, 1'b0, 2'd0);
    drive(1'b1, 4'b1010, {13'd6239, 13'd0, 13'd6240, 13'd0}, 4'b0010, 2'd1, 1'b1, 2'd0);
    chk("t3_oor_rom_addr", int'(rom_addr), 0);
    drive(1'b1, 4'b1000, {13'd6239, 13'd0, 13'd6240, 13'd0}, 4'b1000, 2'd3, 1'b0, 2'd3);
    chk("t3_last_rom_addr", int'(rom_addr), 6239);

    // 4: req0 accepted, reset asserted before its response cycle
    drive(1'b1, 4'b0001, {13'd0, 13'd0, 13'd0, 13'd2}, 4'b0001, 2'd0, 1'b0, 2'd0);
    void'(sb_q.pop_back());
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 4'b0000, '0, 4'b0000, 2'd0, 1'b0, 2'd0);
    drive(1'b1, 4'b1111, ADDR_0123, 4'b0001, 2'd0, 1'b0, 2'd0);

    // 5: arb_en low for 3 cycles, grants resume from held pointer
    drive(1'b1, 4'b1111, ADDR_0123, 4'b0010, 2'd1, 1'b0, 2'd1);
    for (int k = 0; k < 3; k++)
      drive(1'b0, 4'b1111, ADDR_0123, 4'b0000, 2'd0, 1'b0, 2'd0);
    drive(1'b1, 4'b1111, ADDR_0123, 4'b0100, 2'd2, 1'b0, 2'd2);
    drive(1'b1, 4'b1111, ADDR_0123, 4'b1000, 2'd3, 1'b0, 2'd3);

    // 6: only req 3 valid for 5 cycles
    for (int k = 0; k < 5; k++)
      drive(1'b1, 4'b1000, {13'd7, 13'd0, 13'd0, 13'd0}, 4'b1000, 2'd3, 1'b0, 2'd3);

    for (int k = 0; k < 3; k++)
      drive(1'b1, 4'b0000, '0, 4'b0000, 2'd0, 1'b0, 2'd0);
    @(posedge clk);
    #1;
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
